// File: rtl/bp_pkg.sv
// Shared branch-predictor helpers: counter init/saturation and gshare indexing.
package bp_pkg;

    localparam int unsigned PC_W         = 64;
    localparam int unsigned MAX_CTR_BITS = 4;
    localparam int unsigned MAX_IDX_BITS = 16;

    typedef logic [MAX_CTR_BITS-1:0] ctr_t;
    typedef logic [MAX_IDX_BITS-1:0] idx_t;

    function automatic ctr_t ctr_max(input int unsigned bits);
        return ctr_t'((32'd1 << bits) - 32'd1);
    endfunction

    // Weakly not-taken: just below the MSB threshold, or 0 for 1-bit counters.
    function automatic ctr_t ctr_init(input int unsigned bits);
        return (bits <= 1) ? '0 : ctr_t'((32'd1 << (bits - 32'd1)) - 32'd1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t c, input int unsigned bits);
        return (c >= ctr_max(bits)) ? c : c + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == '0) ? c : c - ctr_t'(1);
    endfunction

    function automatic idx_t gshare_index(input logic [PC_W-1:0] pc, input idx_t hist,
                                          input int unsigned log_entries);
        logic [PC_W-1:0] mask;
        mask = (64'd1 << log_entries) - 64'd1;
        return idx_t'((pc >> 2) & mask) ^ hist;
    endfunction

endpackage

// File: rtl/bht_pattern_table.sv
// Saturating-counter pattern table: two combinational reads, two ordered updates.
module bht_pattern_table
    import bp_pkg::*;
#(
    parameter int unsigned LOG_ENTRIES = 6,
    parameter int unsigned CTR_BITS    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LOG_ENTRIES-1:0] rd_idx0_i,
    input  logic [LOG_ENTRIES-1:0] rd_idx1_i,
    output logic [CTR_BITS-1:0]    rd_ctr0_c,
    output logic [CTR_BITS-1:0]    rd_ctr1_c,
    input  logic                   upd0_i,
    input  logic [LOG_ENTRIES-1:0] upd_idx0_i,
    input  logic                   upd_taken0_i,
    input  logic                   upd1_i,
    input  logic [LOG_ENTRIES-1:0] upd_idx1_i,
    input  logic                   upd_taken1_i
);

    localparam int unsigned ENTRIES = 32'd1 << LOG_ENTRIES;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_init(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];

    function automatic logic [CTR_BITS-1:0] bump(input logic [CTR_BITS-1:0] c, input logic up);
        ctr_t w;
        w = ctr_t'(c);
        return CTR_BITS'(up ? sat_inc(w, CTR_BITS) : sat_dec(w));
    endfunction

    assign rd_ctr0_c = ctr_q[rd_idx0_i];
    assign rd_ctr1_c = ctr_q[rd_idx1_i];

    // Port1 sees port0's result so same-index updates compose in age order.
    always_comb begin
        ctr_d = ctr_q;
        if (upd0_i) begin
            ctr_d[upd_idx0_i] = bump(ctr_d[upd_idx0_i], upd_taken0_i);
        end
        if (upd1_i) begin
            ctr_d[upd_idx1_i] = bump(ctr_d[upd_idx1_i], upd_taken1_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= '{default: CTR_RST};
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Two-lane gshare direction predictor with retire-time counter training.
// Define GSHARE_SPEC_HIST_EN for speculative fetch-side history with mispredict recovery.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned HIST_BITS   = 6,
    parameter int unsigned LOG_ENTRIES = 6,
    parameter int unsigned CTR_BITS    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PC_W-1:0]      if_pc,
    input  logic                 if_valid0,
    input  logic                 if_valid1,
    input  logic                 if_is_cbr0,
    input  logic                 if_is_cbr1,
    output logic                 if_taken0,
    output logic                 if_taken1,
    output logic [HIST_BITS-1:0] if_bhr0,
    output logic [HIST_BITS-1:0] if_bhr1,
    input  logic                 rob_retire_br0,
    input  logic                 rob_retire_br1,
    input  logic [PC_W-1:0]      rob_retire_pc0,
    input  logic [PC_W-1:0]      rob_retire_pc1,
    input  logic [HIST_BITS-1:0] rob_retire_bhr0,
    input  logic [HIST_BITS-1:0] rob_retire_bhr1,
    input  logic                 rob_retire_taken0,
    input  logic                 rob_retire_taken1,
    input  logic                 rob_mis_pred,
    input  logic [HIST_BITS-1:0] rob_mis_bhr,
    input  logic                 rob_mis_taken
);

    logic [HIST_BITS-1:0]   bhr_q, bhr_d, hist1;
    logic [PC_W-1:0]        pc1;
    logic                   lane0_cbr, lane1_cbr, pred0, pred1;
    logic [LOG_ENTRIES-1:0] rd_idx0, rd_idx1, upd_idx0, upd_idx1;
    logic [CTR_BITS-1:0]    rd_ctr0, rd_ctr1;

    function automatic logic [HIST_BITS-1:0] shift_in(input logic [HIST_BITS-1:0] h, input logic b);
        return HIST_BITS'({h, b});
    endfunction

    function automatic logic [LOG_ENTRIES-1:0] lookup(input logic [PC_W-1:0] pc,
                                                      input logic [HIST_BITS-1:0] h);
        return LOG_ENTRIES'(gshare_index(pc, idx_t'(h), LOG_ENTRIES));
    endfunction

    assign pc1       = if_pc + PC_W'(4);
    assign lane0_cbr = if_valid0 & if_is_cbr0;
    assign lane1_cbr = if_valid1 & if_is_cbr1;
    assign pred0     = lane0_cbr & rd_ctr0[CTR_BITS-1];
    // A taken lane0 redirects fetch, so lane1 is squashed.
    assign pred1     = lane1_cbr & ~pred0 & rd_ctr1[CTR_BITS-1];

`ifdef GSHARE_SPEC_HIST_EN
    assign hist1 = lane0_cbr ? shift_in(bhr_q, pred0) : bhr_q;
`else
    logic unused_mis;
    assign hist1      = bhr_q;
    assign unused_mis = ^{rob_mis_pred, rob_mis_bhr, rob_mis_taken};
`endif

    assign rd_idx0  = lookup(if_pc, bhr_q);
    assign rd_idx1  = lookup(pc1, hist1);
    assign upd_idx0 = lookup(rob_retire_pc0, rob_retire_bhr0);
    assign upd_idx1 = lookup(rob_retire_pc1, rob_retire_bhr1);

    assign if_taken0 = reset & pred0;
    assign if_taken1 = reset & pred1;
    assign if_bhr0   = reset ? bhr_q : '0;
    assign if_bhr1   = reset ? hist1 : '0;

    always_comb begin
        bhr_d = bhr_q;
`ifdef GSHARE_SPEC_HIST_EN
        if (lane0_cbr) begin
            bhr_d = shift_in(bhr_d, pred0);
        end
        if (lane1_cbr && !pred0) begin
            bhr_d = shift_in(bhr_d, pred1);
        end
        if (rob_mis_pred) begin
            bhr_d = shift_in(rob_mis_bhr, rob_mis_taken);
        end
`else
        if (rob_retire_br0) begin
            bhr_d = shift_in(bhr_d, rob_retire_taken0);
        end
        if (rob_retire_br1) begin
            bhr_d = shift_in(bhr_d, rob_retire_taken1);
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bhr_q <= '0;
        end else begin
            bhr_q <= bhr_d;
        end
    end

    bht_pattern_table #(
        .LOG_ENTRIES(LOG_ENTRIES),
        .CTR_BITS   (CTR_BITS)
    ) u_pt (
        .clk         (clock),
        .rst_n       (reset),
        .rd_idx0_i   (rd_idx0),
        .rd_idx1_i   (rd_idx1),
        .rd_ctr0_c   (rd_ctr0),
        .rd_ctr1_c   (rd_ctr1),
        .upd0_i      (rob_retire_br0),
        .upd_idx0_i  (upd_idx0),
        .upd_taken0_i(rob_retire_taken0),
        .upd1_i      (rob_retire_br1),
        .upd_idx1_i  (upd_idx1),
        .upd_taken1_i(rob_retire_taken1)
    );

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor (both GSHARE_SPEC_HIST_EN builds).
module tb_gshare_predictor;

    localparam int unsigned H = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic [63:0]   if_pc;
    logic          if_valid0, if_valid1, if_is_cbr0, if_is_cbr1;
    logic          if_taken0, if_taken1;
    logic [H-1:0]  if_bhr0, if_bhr1;
    logic          rob_retire_br0, rob_retire_br1;
    logic [63:0]   rob_retire_pc0, rob_retire_pc1;
    logic [H-1:0]  rob_retire_bhr0, rob_retire_bhr1;
    logic          rob_retire_taken0, rob_retire_taken1;
    logic          rob_mis_pred;
    logic [H-1:0]  rob_mis_bhr;
    logic          rob_mis_taken;

    int checks   = 0;
    int failures = 0;

    gshare_predictor dut (
        .clock(clock), .reset(reset), .if_pc(if_pc),
        .if_valid0(if_valid0), .if_valid1(if_valid1),
        .if_is_cbr0(if_is_cbr0), .if_is_cbr1(if_is_cbr1),
        .if_taken0(if_taken0), .if_taken1(if_taken1),
        .if_bhr0(if_bhr0), .if_bhr1(if_bhr1),
        .rob_retire_br0(rob_retire_br0), .rob_retire_br1(rob_retire_br1),
        .rob_retire_pc0(rob_retire_pc0), .rob_retire_pc1(rob_retire_pc1),
        .rob_retire_bhr0(rob_retire_bhr0), .rob_retire_bhr1(rob_retire_bhr1),
        .rob_retire_taken0(rob_retire_taken0), .rob_retire_taken1(rob_retire_taken1),
        .rob_mis_pred(rob_mis_pred), .rob_mis_bhr(rob_mis_bhr), .rob_mis_taken(rob_mis_taken)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        if_pc = '0; if_valid0 = 0; if_valid1 = 0; if_is_cbr0 = 0; if_is_cbr1 = 0;
        rob_retire_br0 = 0; rob_retire_br1 = 0; rob_retire_pc0 = '0; rob_retire_pc1 = '0;
        rob_retire_bhr0 = '0; rob_retire_bhr1 = '0; rob_retire_taken0 = 0; rob_retire_taken1 = 0;
        rob_mis_pred = 0; rob_mis_bhr = '0; rob_mis_taken = 0;
    endtask

    task automatic fetch(input logic [63:0] pc, input logic v0, input logic c0,
                         input logic v1, input logic c1);
        if_pc = pc; if_valid0 = v0; if_is_cbr0 = c0; if_valid1 = v1; if_is_cbr1 = c1;
    endtask

    task automatic retire(input logic b0, input logic [63:0] p0, input logic t0,
                          input logic b1, input logic [63:0] p1, input logic t1);
        rob_retire_br0 = b0; rob_retire_pc0 = p0; rob_retire_bhr0 = '0; rob_retire_taken0 = t0;
        rob_retire_br1 = b1; rob_retire_pc1 = p1; rob_retire_bhr1 = '0; rob_retire_taken1 = t1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        fetch(64'h40, 1, 1, 1, 1);
        retire(1, 64'h40, 1, 1, 64'h40, 1);
        #2;
        chk("rst_taken0", 8'(if_taken0), 8'h0);
        chk("rst_taken1", 8'(if_taken1), 8'h0);
        chk("rst_bhr0", 8'(if_bhr0), 8'h00);
        chk("rst_bhr1", 8'(if_bhr1), 8'h00);
        tick(); tick();
        reset = 1'b1;
        idle();

        // Cold lookup at 0x40 (index 16, counter 1)
        fetch(64'h40, 1, 1, 0, 0); #1;
        chk("cold_taken0", 8'(if_taken0), 8'h0);
        chk("cold_bhr0", 8'(if_bhr0), 8'h00);
        tick(); idle(); #1;
        chk("cold_bhr_next", 8'(if_bhr0), 8'h00);

`ifdef GSHARE_SPEC_HIST_EN
        retire(1, 64'h40, 1, 1, 64'h40, 1);
        tick(); idle(); #1;
        chk("ret_no_shift", 8'(if_bhr0), 8'h00);
        fetch(64'h40, 1, 1, 0, 0); #1;
        chk("trained_taken0", 8'(if_taken0), 8'h1);
        tick(); idle(); #1;
        chk("bhr_after_taken", 8'(if_bhr0), 8'h01);

        // BHR=000001, lane0 idx 33, lane1 hist 000010 -> idx 35, both not taken
        fetch(64'h80, 1, 1, 1, 1); #1;
        chk("two_taken0", 8'(if_taken0), 8'h0);
        chk("two_taken1", 8'(if_taken1), 8'h0);
        chk("two_bhr1", 8'(if_bhr1), 8'h02);
        tick(); idle(); #1;
        chk("two_bhr_next", 8'(if_bhr0), 8'h04);

        // BHR=000100, lane0 idx 20^4=16 taken, lane1 squashed
        fetch(64'h50, 1, 1, 1, 1); #1;
        chk("sq_taken0", 8'(if_taken0), 8'h1);
        chk("sq_taken1", 8'(if_taken1), 8'h0);
        chk("sq_bhr1", 8'(if_bhr1), 8'h09);
        tick(); idle(); #1;
        chk("sq_bhr_next", 8'(if_bhr0), 8'h09);

        fetch(64'h80, 1, 1, 1, 1);
        rob_mis_pred = 1; rob_mis_bhr = 6'b101010; rob_mis_taken = 1;
        tick(); idle(); #1;
        chk("mis_recover", 8'(if_bhr0), 8'h15);

        // Same-index double not-taken from 1: 1->0->0 (idx 32 = 53^21)
        retire(1, 64'h80, 0, 1, 64'h80, 0);
        tick(); idle();
        fetch(64'hD4, 1, 1, 0, 0); #1;
        chk("sat_low_1", 8'(if_taken0), 8'h0);
        idle();
        retire(1, 64'h80, 0, 1, 64'h80, 0);
        tick(); idle();
        fetch(64'hD4, 1, 1, 0, 0); #1;
        chk("sat_low_2", 8'(if_taken0), 8'h0);
        idle();
`else
        retire(1, 64'h40, 1, 1, 64'h40, 1);
        tick(); idle(); #1;
        chk("ret_bhr0", 8'(if_bhr0), 8'h03);
        chk("ret_bhr1", 8'(if_bhr1), 8'h03);
        retire(1, 64'h44, 1, 1, 64'h44, 1);
        tick(); idle(); #1;
        chk("ret_bhr_f", 8'(if_bhr0), 8'h0F);
        for (int i = 0; i < 3; i++) begin
            retire(1, 64'h80, 0, 1, 64'h80, 0);
            tick();
        end
        idle(); #1;
        chk("ret_bhr_zero", 8'(if_bhr0), 8'h00);

        fetch(64'h80, 1, 1, 0, 0); #1;
        chk("sat_low", 8'(if_taken0), 8'h0);
        fetch(64'h40, 1, 1, 1, 1); #1;
        chk("sq_taken0", 8'(if_taken0), 8'h1);
        chk("sq_taken1", 8'(if_taken1), 8'h0);
        fetch(64'h3C, 1, 1, 1, 1); #1;
        chk("l1_taken0", 8'(if_taken0), 8'h0);
        chk("l1_taken1", 8'(if_taken1), 8'h1);
        chk("l1_bhr1", 8'(if_bhr1), 8'h00);
        fetch(64'h40, 0, 1, 0, 0); #1;
        chk("gate_invalid", 8'(if_taken0), 8'h0);
        fetch(64'h40, 1, 0, 0, 0); #1;
        chk("gate_not_cbr", 8'(if_taken0), 8'h0);
        idle();

        // Counter 16 saturates at 3, then two single decrements: 3->2 (taken), 2->1 (not)
        retire(1, 64'h40, 1, 1, 64'h40, 1);
        tick(); idle();
        fetch(64'h4C, 1, 1, 0, 0); #1;
        chk("sat_high", 8'(if_taken0), 8'h1);
        idle();
        retire(1, 64'h40, 0, 0, 64'h0, 0);
        tick(); idle();
        fetch(64'h58, 1, 1, 0, 0); #1;
        chk("dec_to_2", 8'(if_taken0), 8'h1);
        idle();
        retire(1, 64'h40, 0, 0, 64'h0, 0);
        tick(); idle();
        fetch(64'h70, 1, 1, 0, 0); #1;
        chk("dec_to_1", 8'(if_taken0), 8'h0);

        fetch(64'h40, 1, 1, 1, 1);
        rob_mis_pred = 1; rob_mis_bhr = 6'b101010; rob_mis_taken = 1;
        tick(); idle(); #1;
        chk("mis_ignored", 8'(if_bhr0), 8'h0C);

        retire(1, 64'hC0, 1, 1, 64'hC0, 0);
        tick(); idle(); #1;
        chk("ret_order", 8'(if_bhr0), 8'h32);
`endif

        // Mid-operation reset discards the pending retire and restores init state
        retire(1, 64'h40, 1, 1, 64'h40, 1);
        fetch(64'h40, 1, 1, 1, 1);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_bhr0", 8'(if_bhr0), 8'h00);
        chk("mid_rst_taken0", 8'(if_taken0), 8'h0);
        tick();
        reset = 1'b1;
        idle();
        fetch(64'h40, 1, 1, 0, 0); #1;
        chk("post_rst_taken0", 8'(if_taken0), 8'h0);
        chk("post_rst_bhr0", 8'(if_bhr0), 8'h00);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter HIST_BITS, default 6: global history length; legal range 1..LOG_ENTRIES.
REQ-002 SHALL have parameter LOG_ENTRIES, default 6: log2 of the pattern-table entry count.
REQ-003 SHALL have parameter CTR_BITS, default 2: saturating-counter width; legal range 1..4.
REQ-004 SHALL have port clock  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-006 SHALL have ports if_pc  in  64: fetch-bundle PC; lane0 is at if_pc, lane1 is at if_pc+4.
REQ-007 SHALL have ports if_valid0/if_valid1  in  1 each: lane holds a valid instruction.
REQ-008 SHALL have ports if_is_cbr0/if_is_cbr1  in  1 each: lane is a conditional branch (decoded externally).
REQ-009 SHALL have ports if_taken0/if_taken1  out  1 each: taken prediction per lane.
REQ-010 SHALL have ports if_bhr0/if_bhr1  out  HIST_BITS each: history used for the lane's lookup, carried by the ROB.
REQ-011 SHALL have ports rob_retire_br0/1 (in 1), rob_retire_pc0/1 (in 64), rob_retire_bhr0/1 (in HIST_BITS) and rob_retire_taken0/1 (in 1): retiring conditional-branch update ports, with port0 older.
REQ-012 SHALL have ports rob_mis_pred (in 1), rob_mis_bhr (in HIST_BITS) and rob_mis_taken (in 1): mispredict recovery.

Function
REQ-013 SHALL compute index = pc[LOG_ENTRIES+1:2] XOR zero-extended history.
REQ-014 SHALL form the prediction as the counter MSB, read combinationally in the same cycle.
REQ-015 SHALL produce if_takenN = 0 whenever if_validN & if_is_cbrN is low.
REQ-016 SHALL use BHR as lane0 history.
REQ-017 SHALL use lane1 history = {BHR[HIST_BITS-2:0], if_taken0} when lane0 is a valid cbr, and BHR otherwise.
REQ-018 SHALL force if_taken1 = 0 and leave lane1 out of the history when lane0 is predicted taken, since lane1 is squashed.
REQ-019 SHALL update BHR at the next edge by shifting in, LSB-first, each predicted branch in lane order (0, 1 or 2 bits).
REQ-020 SHALL, on rob_mis_pred, set BHR <= {rob_mis_bhr[HIST_BITS-2:0], rob_mis_taken}; this overrides any fetch-side shift in the same cycle.
REQ-021 SHALL, on retire, index with rob_retire_pcN and rob_retire_bhrN; taken increments and not-taken decrements the counter, saturating at 0 and 2^CTR_BITS-1.
REQ-022 SHALL, when both retire ports hit the same index, apply port0 then port1 (net effect, e.g. 2 increments from 1 gives 3 when CTR_BITS=2).
REQ-023 SHALL write counters at the next edge, with no same-cycle bypass to lookup.
REQ-024 SHALL compute all arithmetic at its declared width, with no implicit truncation warnings; pc bits [1:0] are ignored.

Reset
REQ-025 SHALL, while reset is low, asynchronously clear BHR to 0 and set every counter to 2^(CTR_BITS-1)-1 (weakly not-taken; 0 when CTR_BITS=1).
REQ-026 SHALL hold if_taken0/1 and if_bhr0/1 at 0 while reset is low.
REQ-027 SHALL ignore retire and mispredict inputs during reset; reset assertion mid-operation discards all pending updates.

Configuration
REQ-028 SHALL, with GSHARE_SPEC_HIST_EN defined, behave per REQ-016..020 (speculative history with recovery).
REQ-029 SHALL, without GSHARE_SPEC_HIST_EN, update BHR only at retire (shift rob_retire_taken0 then rob_retire_taken1 for asserted ports), ignore rob_mis_* entirely, and use BHR for both lanes.

Structure
REQ-030 SHALL place counter-init constants and the sat_inc, sat_dec and gshare_index functions in shared package bp_pkg.
REQ-031 SHALL use sub-module bht_pattern_table: counter array with 2 combinational read ports and 2 ordered saturating update ports.

Verification
REQ-032 Bench SHALL cover reset, then lane0 cbr at if_pc=0x40 -> if_taken0=0, if_bhr0=0; next cycle BHR=000000.
REQ-033 Bench SHALL cover retire pc=0x40, bhr=0, taken twice -> counter[16]=3; then fetch 0x40 with BHR=0 -> if_taken0=1.
REQ-034 Bench SHALL cover both lanes cbr with lane0 predicted not-taken and BHR=000001 -> if_bhr1=000010 and BHR advances 2 bits.
REQ-035 Bench SHALL cover lane0 predicted taken with lane1 cbr -> if_taken1=0 and BHR shifts exactly 1 bit.
REQ-036 Bench SHALL cover rob_mis_pred with rob_mis_bhr=101010, rob_mis_taken=1 and concurrent fetch of 2 cbrs -> BHR=010101 next cycle.
REQ-037 Bench SHALL cover both retire ports on the same index, not-taken, from counter=0 -> stays 0; with macro undefined, mispredict leaves BHR unchanged.
